fetch_buffer: RTL and testbench

- Instruction queue on the consumer side of the fetch stage.
- Accepts (PC, PC+4, instruction) triples produced by fetch and instruction memory, and hands them to decode over a valid/ready handshake.
- Drives the fetch PC-register enable: PC advances only while the buffer can take an entry.
- Discards all queued entries on a redirect from execute.

---
 rtl/fetch_buffer.sv | 110 +++++++++++
 tb/tb_fetch_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: circular buffer of (PC, PC+4, instr) triples with a
// valid/ready output, a fetch PC enable, and redirect flush. Optional bypass: FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc_plus_four,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     fetch_enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_plus_four,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          buf_valid;
  logic          push;
  logic          pop;

  // Both flags come from registered state only, so fetch never sees a loop through in_valid.
  assign fetch_enable = (count_q != FULL);
  assign buf_valid    = (count_q != '0);
  assign count        = count_q;
  assign pop          = buf_valid && out_ready && !flush;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass;
  assign bypass = !buf_valid && in_valid && out_ready && !flush;
  assign push   = in_valid && fetch_enable && !flush && !bypass;
`else
  assign push   = in_valid && fetch_enable && !flush;
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    out_valid        = buf_valid;
    out_pc           = buf_valid ? pc_mem[rd_ptr_q]    : '0;
    out_pc_plus_four = buf_valid ? pc4_mem[rd_ptr_q]   : '0;
    out_instr        = buf_valid ? instr_mem[rd_ptr_q] : '0;
`ifdef FETCH_BUF_BYPASS_EN
    if (bypass) begin
      out_valid        = 1'b1;
      out_pc           = in_pc;
      out_pc_plus_four = in_pc_plus_four;
      out_instr        = in_instr;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly PW bits wide, so +1 wraps modulo DEPTH on its own.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; out_* are masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      pc4_mem[wr_ptr_q]   <= in_pc_plus_four;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=4, XLEN=32); bypass checks follow FETCH_BUF_BYPASS_EN.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_pc_plus_four;
  logic [31:0] in_instr;
  logic        fetch_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_four;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_pc_plus_four(in_pc_plus_four), .in_instr(in_instr),
    .fetch_enable(fetch_enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus_four(out_pc_plus_four), .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid        = v;
    in_pc           = pc;
    in_pc_plus_four = pc + 32'd4;
    in_instr        = instr;
  endtask

  task automatic do_reset();
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (fetch_enable !== 1'b1) begin errors++; $display("FAIL reset_fetch_enable got %b exp 1", fetch_enable); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_payload got pc=%h instr=%h exp 0", out_pc, out_instr); end
  endtask

  task automatic test_single_push();
    do_reset();
    drive(1'b1, 32'h0000_0000, 32'h0000_0013);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got %b exp 0", out_valid); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h0 || out_pc_plus_four !== 32'h4 || out_instr !== 32'h13) begin
      errors++; $display("FAIL single_payload got %h/%h/%h exp 00000000/00000004/00000013", out_pc, out_pc_plus_four, out_instr); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h100 + 32'(i));
      step();
    end
    drive(1'b1, 32'h10, 32'h1FF);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (fetch_enable !== 1'b0) begin errors++; $display("FAIL full_fetch_enable got %b exp 0", fetch_enable); end
    step();
    checks++; if (count !== 3'd4 || out_pc !== 32'h0) begin errors++; $display("FAIL full_hold got count=%0d pc=%h exp 4/00000000", count, out_pc); end
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    checks++; if (fetch_enable !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL full_pop got fe=%b count=%0d exp 1/3", fetch_enable, count); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_pc !== 32'(4 * i) || out_instr !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL full_drain%0d got pc=%h instr=%h exp %h/%h", i, out_pc, out_instr, 32'(4 * i), 32'h100 + 32'(i)); end
      step();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 32'h10, 32'hA0); step();
    drive(1'b1, 32'h14, 32'hA1); step();
    drive(1'b1, 32'h20, 32'hA2);
    out_ready = 1'b1;
    #1;
    checks++; if (count !== 3'd2 || out_pc !== 32'h10) begin errors++; $display("FAIL b2b_pre got count=%0d pc=%h exp 2/00000010", count, out_pc); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 3'd2 || out_pc !== 32'h14) begin errors++; $display("FAIL b2b_same got count=%0d pc=%h exp 2/00000014", count, out_pc); end
    step();
    checks++; if (count !== 3'd1 || out_pc !== 32'h20 || out_instr !== 32'hA2) begin
      errors++; $display("FAIL b2b_last got count=%0d pc=%h instr=%h exp 1/00000020/000000a2", count, out_pc, out_instr); end
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 32'h200, 32'hB00); step();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hB00 + 32'(i));
      out_ready = 1'b1;
      #1;
      checks++; if (count !== 3'd1 || out_pc !== 32'h200 + 32'(4 * (i - 1)) || out_pc_plus_four !== 32'h200 + 32'(4 * i) || out_instr !== 32'hB00 + 32'(i - 1)) begin
        errors++; $display("FAIL wrap%0d got count=%0d pc=%h pc4=%h instr=%h exp 1/%h", i, count, out_pc, out_pc_plus_four, out_instr, 32'h200 + 32'(4 * (i - 1))); end
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (out_pc !== 32'h220 || count !== 3'd1) begin errors++; $display("FAIL wrap_tail got pc=%h count=%0d exp 00000220/1", out_pc, count); end
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 32'hC0 + 32'(i));
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", count); end
    drive(1'b1, 32'h99, 32'hDEAD);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || fetch_enable !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL flush_state got count=%0d valid=%b fe=%b pc=%h exp 0/0/1/0", count, out_valid, fetch_enable, out_pc); end
    drive(1'b1, 32'h100, 32'hE0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 3'd1 || out_pc !== 32'h100 || out_instr !== 32'hE0) begin
      errors++; $display("FAIL flush_next got count=%0d pc=%h instr=%h exp 1/00000100/000000e0", count, out_pc, out_instr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 32'h300, 32'hF0); step();
    drive(1'b1, 32'h304, 32'hF1); step();
    drive(1'b0, 32'h0, 32'h0);
    #2;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre got %0d exp 2", count); end
    rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || fetch_enable !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL areset_state got count=%0d valid=%b fe=%b pc=%h exp 0/0/1/0", count, out_valid, fetch_enable, out_pc); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1'b1, 32'h40, 32'h77);
    out_ready = 1'b1;
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_pc_plus_four !== 32'h44 || out_instr !== 32'h77) begin
      errors++; $display("FAIL bypass_same got valid=%b pc=%h pc4=%h instr=%h exp 1/00000040/00000044/00000077", out_valid, out_pc, out_pc_plus_four, out_instr); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_after got count=%0d valid=%b exp 0/0", count, out_valid); end
`else
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL nobypass_same got valid=%b pc=%h exp 0/0", out_valid, out_pc); end
    step();
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || count !== 3'd1) begin
      errors++; $display("FAIL nobypass_next got valid=%b pc=%h count=%0d exp 1/00000040/1", out_valid, out_pc, count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
